bus_fabric: RTL and testbench
=============================

// Module: bus_fabric
// PURPOSE
//  Parametrised 6502 bus interconnect: decodes CPU_AB into N slave selects, muxes registered slave
//  read data to CPU_DI, merges slave RDYs with per-slave wait states, and merges IRQs through a
//  mask register. Optional watchdog frees the CPU from a hung slave. Sits between cpu and all peripherals.
// PARAMETERS
//  NSLV     4               number of slave channels, 1..16
//  BASES    {NSLV{16'h0000}} packed NSLV*16; base address of slave k at [16k+15:16k]
//  MASKS    {NSLV{16'h8000}} packed NSLV*16; slave k hit when (ab & MASK_k) == (BASE_k & MASK_k)
//  WAITS    {NSLV{4'h0}}     packed NSLV*4; extra stall cycles inserted on each access to slave k
//  CTRL_BASE 16'hF7F0        base of 16-byte internal register window, match on ab[15:4]
//  TIMEOUT  256              stall cycles before watchdog fires, 2..65535 (BUS_TIMEOUT_EN only)
//  DEF_DI   8'hFF            read data for unmapped address or timed-out access
// PORTS
//  clk      in   1        system clock
//  rst      in   1        asynchronous reset, active high
//  cpu_ab   in   16       CPU address
//  cpu_we   in   1        CPU write enable
//  cpu_do   in   8        CPU write data (internal registers only)
//  cpu_di   out  8        CPU read data
//  cpu_rdy  out  1        CPU ready, low stalls the CPU
//  cpu_irq  out  1        merged interrupt request
//  slv_sel  out  NSLV     one-hot slave chip selects (combinational)
//  slv_do   in   NSLV*8   slave read data, slave k at [8k+7:8k]
//  slv_rdy  in   NSLV     per-slave ready, 1 when slave idle/unused
//  slv_irq  in   NSLV     per-slave interrupt request, level
// BEHAVIOUR
//  Decode: combinational. Ctrl window beats all slaves; among slaves the lowest index hit wins.
//   No hit -> slv_sel=0, cpu_rdy=1, read returns DEF_DI.
//  Read mux: select index (slave/ctrl/default/timeout) is registered only on clk edges with cpu_rdy=1;
//   cpu_di = that source combinationally, so data follows one cycle after address (sync-RAM timing);
//   index holds during stalls. Reset value: default source (cpu_di = DEF_DI).
//  Wait states: rdy_q <= cpu_rdy (reset 1). new_acc = rdy_q. On new_acc to slave k with W=WAITS_k>0:
//   cpu_rdy=0, ws_cnt<=W. While ws_cnt>1: cpu_rdy=0, decrement. At ws_cnt==1: cpu_rdy=slv_rdy[k];
//   ws_cnt->0 when cpu_rdy=1. Ready slave: W+1 cycles per access; W=0: cpu_rdy=slv_rdy[k] directly.
//   ws_cnt reset 0. Address change mid-wait is not legal (CPU holds AB while stalled).
//  Ctrl registers (offset ab[3:0], 0 wait, always ready; unlisted offsets read 0, writes ignored):
//   0 IRQ_STAT  RO  slv_irq & irq_en (bits >=NSLV read 0; NSLV>8 -> 1 also holds bits 15:8 same way)
//   2 IRQ_EN    RW  low 8 enables, reset 0;  3 IRQ_EN_HI RW bits 15:8, reset 0
//   4 ERR       bit0 timeout sticky, write 1 clears; bits 7:4 slave index of last timeout; reset 0
//  Writes: take effect on the clk edge where cpu_we=1, ctrl hit, cpu_rdy=1.
//  cpu_irq = |(slv_irq & irq_en), registered, reset 0 (one cycle latency).
//  Reset mid-access: all state to reset values immediately; cpu_rdy=1 after reset.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: to_cnt counts consecutive cycles with cpu_rdy=0, cleared when cpu_rdy=1.
//   When to_cnt==TIMEOUT-1, cpu_rdy forced 1 that cycle, read source = timeout (DEF_DI), ERR.bit0 set,
//   ERR[7:4] = slave index; slv_sel stays asserted that cycle (slave sees write if cpu_we).
//   New timeout while ERR.bit0 set overwrites index; clear and set same cycle -> set wins.
//  Not defined: no counter, stall lasts indefinitely, ERR reads 8'h00, writes ignored.
// TESTING
//  1 NSLV=4, slave2 BASE 16'hF000 MASK 16'hFF00, W=0: read F005 with slv_do2=8'h5A -> sel=4'b0100,
//    cpu_rdy stays 1, cpu_di=8'h5A one cycle after address.
//  2 slave1 WAITS=3, slv_rdy=1: read -> cpu_rdy low exactly 3 cycles, high on 4th; cpu_di=slv_do1.
//  3 slave0 slv_rdy low 5 cycles, W=0 -> cpu_rdy mirrors slv_rdy; mux index held; data correct on release.
//  4 write 8'h05 to CTRL_BASE+2, slv_irq=4'b0110 -> cpu_irq=1 next cycle, IRQ_STAT reads 8'h04.
//  5 BUS_TIMEOUT_EN, TIMEOUT=16, slave3 slv_rdy stuck 0 -> cpu_rdy=1 on 16th stall cycle, cpu_di=8'hFF,
//    ERR=8'h31; write 8'h01 to ERR -> reads 8'h30.
//  6 read unmapped address -> slv_sel=0, cpu_rdy=1, cpu_di=8'hFF; assert rst mid-wait -> cpu_rdy=1, irq=0.

Source files
------------

// File: rtl/bus_fabric.sv
// bus_fabric: 6502 bus interconnect that decodes the CPU address into slave selects, muxes the
// registered read source onto cpu_di, inserts per-slave wait states and merges masked IRQs.
// Define BUS_TIMEOUT_EN to add a watchdog that releases the CPU from a hung slave.
module bus_fabric #(
    parameter int                 NSLV      = 4,
    parameter logic [NSLV*16-1:0] BASES     = {NSLV{16'h0000}},
    parameter logic [NSLV*16-1:0] MASKS     = {NSLV{16'h8000}},
    parameter logic [NSLV*4-1:0]  WAITS     = {NSLV{4'h0}},
    parameter logic [15:0]        CTRL_BASE = 16'hF7F0,
    parameter int                 TIMEOUT   = 256,
    parameter logic [7:0]         DEF_DI    = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_ab,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_do,
    output logic [7:0]        cpu_di,
    output logic              cpu_rdy,
    output logic              cpu_irq,
    output logic [NSLV-1:0]   slv_sel,
    input  logic [NSLV*8-1:0] slv_do,
    input  logic [NSLV-1:0]   slv_rdy,
    input  logic [NSLV-1:0]   slv_irq
);
    typedef enum logic [1:0] {SRC_DEF, SRC_SLV, SRC_CTRL} src_t;

    logic            w_ctrl;
    logic            w_hit;
    logic            w_slv;
    logic            w_srdy;
    logic            w_rdy_raw;
    logic            w_to;
    logic [3:0]      w_idx;
    logic [3:0]      w_wait;
    logic [NSLV-1:0] w_sel;
    logic [15:0]     w_stat;
    logic [7:0]      w_err;
    logic [7:0]      w_creg;
    logic [7:0]      w_sdat;
    src_t            r_src;
    logic [3:0]      r_idx;
    logic [3:0]      r_off;
    logic [3:0]      r_ws;
    logic            r_rdy_q;
    logic            r_irq;
    logic [15:0]     r_en;

    assign w_ctrl  = cpu_ab[15:4] == CTRL_BASE[15:4];
    assign w_slv   = w_hit & ~w_ctrl;
    assign slv_sel = w_slv ? w_sel : '0;
    assign w_stat  = 16'(slv_irq) & r_en;
    assign cpu_irq = r_irq;

    // Priority decode: scanning downwards leaves the lowest matching slave selected
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_wait = '0;
        w_srdy = 1'b1;
        w_sel  = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((cpu_ab & MASKS[16*k +: 16]) == (BASES[16*k +: 16] & MASKS[16*k +: 16])) begin
                w_hit    = 1'b1;
                w_idx    = 4'(k);
                w_wait   = WAITS[4*k +: 4];
                w_srdy   = slv_rdy[k];
                w_sel    = '0;
                w_sel[k] = 1'b1;
            end
        end
    end

    // Data of the slave latched by the last completed access
    always_comb begin
        w_sdat = DEF_DI;
        for (int k = 0; k < NSLV; k++)
            if (r_idx == 4'(k)) w_sdat = slv_do[8*k +: 8];
    end

    // Ctrl register readback and final read mux; ready generation with wait-state countdown
    always_comb begin
        w_creg    = r_off == 4'd0 ? w_stat[7:0] :
                    r_off == 4'd1 ? w_stat[15:8] :
                    r_off == 4'd2 ? r_en[7:0] :
                    r_off == 4'd3 ? r_en[15:8] :
                    r_off == 4'd4 ? w_err : 8'h00;
        cpu_di    = r_src == SRC_SLV ? w_sdat : r_src == SRC_CTRL ? w_creg : DEF_DI;
        w_rdy_raw = !w_slv ? 1'b1 :
                    w_wait == 4'd0 ? w_srdy :
                    (r_rdy_q || r_ws > 4'd1) ? 1'b0 : w_srdy;
        cpu_rdy   = w_rdy_raw | w_to;
    end

    // Access tracking, read source capture, IRQ enable writes and merged IRQ register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src   <= SRC_DEF;
            r_idx   <= '0;
            r_off   <= '0;
            r_ws    <= '0;
            r_rdy_q <= 1'b1;
            r_irq   <= 1'b0;
            r_en    <= '0;
        end else begin
            r_rdy_q <= cpu_rdy;
            r_ws    <= cpu_rdy ? 4'd0 : r_rdy_q ? w_wait : (r_ws > 4'd1) ? r_ws - 4'd1 : r_ws;
            r_irq   <= |w_stat;
            if (cpu_rdy) begin
                r_src <= w_to ? SRC_DEF : w_ctrl ? SRC_CTRL : w_slv ? SRC_SLV : SRC_DEF;
                r_idx <= w_idx;
                r_off <= cpu_ab[3:0];
                if (cpu_we && w_ctrl && cpu_ab[3:0] == 4'd2) r_en[7:0] <= cpu_do;
                if (cpu_we && w_ctrl && cpu_ab[3:0] == 4'd3) r_en[15:8] <= cpu_do;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_to;
    logic        r_err_to;
    logic [3:0]  r_err_idx;

    assign w_to  = !w_rdy_raw && r_to == 16'(TIMEOUT - 1);
    assign w_err = {r_err_idx, 3'b000, r_err_to};

    // Watchdog: count consecutive stall cycles and record the hung slave when it expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to      <= '0;
            r_err_to  <= 1'b0;
            r_err_idx <= '0;
        end else begin
            r_to <= cpu_rdy ? 16'd0 : r_to + 16'd1;
            if (w_to) begin
                r_err_to  <= 1'b1;
                r_err_idx <= w_idx;
            end else if (cpu_rdy && cpu_we && w_ctrl && cpu_ab[3:0] == 4'd4 && cpu_do[0]) begin
                r_err_to <= 1'b0;
            end
        end
    end
`else
    assign w_to  = 1'b0;
    assign w_err = 8'h00;
`endif
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: randomized accesses checked against an address-range / cycle-count reference model
module tb_bus_fabric;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_ab;
    logic        cpu_we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        cpu_irq;
    logic [3:0]  slv_sel;
    logic [31:0] slv_do;
    logic [3:0]  slv_rdy;
    logic [3:0]  slv_irq;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          waits_m [4] = '{0, 3, 0, 2};
    logic [15:0] en_m;
    logic        err_to_m;
    logic [3:0]  err_idx_m;
    logic        exp_irq;
    int          prev_tgt;
    logic [3:0]  prev_off;
    logic        prev_we;

    bus_fabric #(
        .NSLV(4),
        .BASES({16'hF000, 16'hF000, 16'h8000, 16'h0000}),
        .MASKS({16'hF000, 16'hFF00, 16'hC000, 16'h8000}),
        .WAITS({4'h2, 4'h0, 4'h3, 4'h0}),
        .CTRL_BASE(16'hF7F0),
        .TIMEOUT(16),
        .DEF_DI(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_irq(cpu_irq), .slv_sel(slv_sel),
        .slv_do(slv_do), .slv_rdy(slv_rdy), .slv_irq(slv_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0..3 slave, 4 ctrl window, 5 unmapped, 6 timed-out access
    function automatic int ref_tgt(input logic [15:0] a);
        if (a >= 16'hF7F0 && a <= 16'hF7FF) return 4;
        if (a < 16'h8000) return 0;
        if (a < 16'hC000) return 1;
        if (a >= 16'hF000 && a < 16'hF100) return 2;
        if (a >= 16'hF000) return 3;
        return 5;
    endfunction

    function automatic logic [7:0] ref_rd(input int tgt, input logic [3:0] off);
        if (tgt < 4) return slv_do[8*tgt +: 8];
        if (tgt != 4) return 8'hFF;
        case (off)
            4'd0: return {4'h0, slv_irq & en_m[3:0]};
            4'd2: return en_m[7:0];
            4'd3: return en_m[15:8];
`ifdef BUS_TIMEOUT_EN
            4'd4: return {err_idx_m, 3'b000, err_to_m};
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        logic nxt;
        nxt = |(slv_irq & en_m[3:0]);
        @(posedge clk);
        exp_irq = nxt;
        #1;
    endtask

    task automatic model_reset();
        en_m = '0; err_to_m = 1'b0; err_idx_m = '0; exp_irq = 1'b0;
        prev_tgt = 5; prev_off = '0; prev_we = 1'b0;
    endtask

    // One CPU access; slave ready is random (rnd) or low for the first 'low' cycles, then high
    task automatic do_access(input logic [15:0] ab, input logic we, input logic [7:0] d, input int low,
                             input bit rnd, input logic [31:0] sdo, input logic [3:0] sirq);
        int   tgt;
        int   c;
        bit   done;
        logic exp_rdy;
        tgt = ref_tgt(ab);
        cpu_ab = ab; cpu_we = we; cpu_do = d; slv_do = sdo; slv_irq = sirq;
        c = 0; done = 0;
        while (!done) begin
            slv_rdy = (c < low) ? (rnd ? 4'($urandom) : 4'h0) : 4'hF;
            @(negedge clk);
            if (c == 0 && !prev_we) check("rdata", cpu_di, ref_rd(prev_tgt, prev_off));
            check("sel", slv_sel, tgt < 4 ? 4'(1 << tgt) : 4'h0);
            exp_rdy = tgt >= 4 ? 1'b1 : (c < waits_m[tgt]) ? 1'b0 : slv_rdy[tgt];
            check("rdy", cpu_rdy, exp_rdy);
            check("irq", cpu_irq, exp_irq);
            step();
            if (exp_rdy) begin
                done = 1;
                if (we && tgt == 4) begin
                    if (ab[3:0] == 4'd2) en_m[7:0] = d;
                    if (ab[3:0] == 4'd3) en_m[15:8] = d;
                    if (ab[3:0] == 4'd4 && d[0]) err_to_m = 1'b0;
                end
            end
            c++;
            if (c > 40 && !done) begin
                n_vec++; n_err++;
                $display("FAIL bound: access %h not complete in 40 cycles", ab);
                done = 1;
            end
        end
        prev_tgt = tgt; prev_off = ab[3:0]; prev_we = we;
    endtask

    initial begin
        int          cat;
        logic [15:0] a;
        rst = 1'b1; cpu_ab = 16'hD000; cpu_we = 1'b0; cpu_do = '0;
        slv_do = '0; slv_rdy = 4'hF; slv_irq = 4'hF;
        model_reset();
        @(negedge clk);
        check("rst_di", cpu_di, 8'hFF);
        check("rst_rdy", cpu_rdy, 1'b1);
        check("rst_irq", cpu_irq, 1'b0);
        check("rst_sel", slv_sel, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_access(16'hF005, 1'b0, 8'h00, 0, 0, 32'h005A_0000, 4'h0);
        do_access(16'hD123, 1'b0, 8'h00, 0, 0, 32'h005A_0000, 4'h0);
        do_access(16'h8123, 1'b0, 8'h00, 0, 0, $urandom, 4'h0);
        do_access(16'h0042, 1'b0, 8'h00, 5, 0, $urandom, 4'h0);
        do_access(16'hF7F2, 1'b1, 8'h05, 0, 0, $urandom, 4'b0110);
        do_access(16'hF7F0, 1'b0, 8'h00, 0, 0, $urandom, 4'b0110);
        do_access(16'hE000, 1'b0, 8'h00, 0, 0, $urandom, 4'b0110);
        do_access(16'hF123, 1'b0, 8'h00, 0, 0, $urandom, 4'b0110);

`ifdef BUS_TIMEOUT_EN
        cpu_ab = 16'hF200; cpu_we = 1'b0;
        for (int c = 0; c < 16; c++) begin
            slv_rdy = 4'h0;
            @(negedge clk);
            check("to_rdy", cpu_rdy, c == 15);
            check("to_sel", slv_sel, 4'b1000);
            step();
        end
        err_to_m = 1'b1; err_idx_m = 4'd3; prev_tgt = 6; prev_off = 4'h0; prev_we = 1'b0;
        do_access(16'hF7F4, 1'b0, 8'h00, 0, 0, $urandom, 4'h0);
        do_access(16'hF7F4, 1'b1, 8'h01, 0, 0, $urandom, 4'h0);
        do_access(16'hF7F4, 1'b0, 8'h00, 0, 0, $urandom, 4'h0);
        do_access(16'hD000, 1'b0, 8'h00, 0, 0, $urandom, 4'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            cat = $urandom_range(0, 5);
            case (cat)
                0: a = 16'($urandom_range(0, 16'h7FFF));
                1: a = 16'($urandom_range(16'h8000, 16'hBFFF));
                2: a = 16'($urandom_range(16'hF000, 16'hF0FF));
                3: a = $urandom_range(0, 1) ? 16'($urandom_range(16'hF800, 16'hFFFF))
                                            : 16'($urandom_range(16'hF100, 16'hF7EF));
                4: a = 16'hF7F0 | 16'($urandom_range(0, 15));
                default: a = 16'($urandom_range(16'hC000, 16'hEFFF));
            endcase
            do_access(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 8), 1,
                      $urandom, 4'($urandom));
        end

        do_access(16'hF7F2, 1'b1, 8'h0F, 0, 0, $urandom, 4'hF);
        cpu_ab = 16'h8200; cpu_we = 1'b0; slv_rdy = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rstw_rdy", cpu_rdy, 1'b0);
            if (c == 1) check("rstw_irq", cpu_irq, 1'b1);
            step();
        end
        rst = 1'b1; cpu_ab = 16'hD000;
        @(negedge clk);
        check("rstm_rdy", cpu_rdy, 1'b1);
        check("rstm_di", cpu_di, 8'hFF);
        check("rstm_irq", cpu_irq, 1'b0);
        check("rstm_sel", slv_sel, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        do_access(16'h8200, 1'b0, 8'h00, 0, 0, $urandom, 4'hF);
        do_access(16'hD000, 1'b0, 8'h00, 0, 0, $urandom, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
